pool_module: RTL

Streaming 2x2/stride-2 signed max-pool stage directly upstream of the fully-connected stage. Accepts a 6x6x3 signed 8-bit feature map one pixel (all 3 channels) per cycle in raster order. Emits the 3x3x3 pooled vector as one flat word with a held valid, in the exact packing the fully-connected stage consumes. Double-buffered: the next frame streams in while the previous result is still held.

---
 rtl/pool_pkg.sv | 18 +
 rtl/pool_module_max.sv | 20 ++
 rtl/pool_module.sv | 98 +++++++++
 3 files changed

// File: rtl/pool_pkg.sv
// Shared geometry and packing for the max-pool stage and its fully-connected consumer.
// pool_idx() is the single definition of the flat-vector element order.
package pool_pkg;

  localparam int DW        = 8;
  localparam int C         = 3;
  localparam int W         = 6;
  localparam int P         = W / 2;
  localparam int POOL_BITS = C * P * P * DW;
  localparam int PIX_BITS  = C * DW;
  localparam int CW        = $clog2(W);

  // Channel-major, then pooled row, then pooled column.
  function automatic int pool_idx(input int c, input int pr, input int pc);
    return c * P * P + pr * P + pc;
  endfunction

endpackage

// File: rtl/pool_module_max.sv
// C-lane signed max of an accumulator and a pixel; init passes the pixel through
// so the first pixel of a 2x2 window seeds the cell.
module pool_max
  import pool_pkg::*;
(
  input  logic                init,
  input  logic [PIX_BITS-1:0] acc,
  input  logic [PIX_BITS-1:0] pix,
  output logic [PIX_BITS-1:0] res
);

  for (genvar gi = 0; gi < C; gi++) begin : g_lane
    logic signed [DW-1:0] a_lane;
    logic signed [DW-1:0] p_lane;
    assign a_lane = acc[gi*DW +: DW];
    assign p_lane = pix[gi*DW +: DW];
    assign res[gi*DW +: DW] = (init || (p_lane > a_lane)) ? p_lane : a_lane;
  end

endmodule

// File: rtl/pool_module.sv
// Streaming 2x2/stride-2 signed max-pool over a WxWxC frame, one pixel per cycle.
// The result register is double-buffered against the working vector; only the last pixel can stall.
module pool_module
  import pool_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PIX_BITS-1:0]  pix_in,
  input  logic                 pix_vld,
  output logic                 pix_rdy,
  output logic [POOL_BITS-1:0] pool_lin,
  output logic                 pool_vld,
  input  logic                 pool_ack
);

  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [CW-1:0]        col_q, col_d;
  logic [CW-1:0]        row_q, row_d;
  logic [POOL_BITS-1:0] work_q, work_d;
  logic [POOL_BITS-1:0] pool_lin_q, pool_lin_d;
  logic                 pool_vld_q, pool_vld_d;

  logic                 at_last;
  logic                 xfer;
  logic                 cell_init;
  logic [PIX_BITS-1:0]  acc_lanes;
  logic [PIX_BITS-1:0]  max_lanes;

  assign at_last   = (row_q == LAST) && (col_q == LAST);
  assign pix_rdy   = !(at_last && pool_vld_q && !pool_ack);
  assign xfer      = pix_vld && pix_rdy;
  assign cell_init = !row_q[0] && !col_q[0];

  // Gather the current cell of every channel into one C-lane word.
  for (genvar gi = 0; gi < C; gi++) begin : g_sel
    assign acc_lanes[gi*DW +: DW] =
      work_q[pool_idx(gi, int'(row_q >> 1), int'(col_q >> 1))*DW +: DW];
  end

  pool_max u_max (
    .init (cell_init),
    .acc  (acc_lanes),
    .pix  (pix_in),
    .res  (max_lanes)
  );

  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    work_d     = work_q;
    pool_lin_d = pool_lin_q;
    pool_vld_d = pool_vld_q;

    if (pool_ack) begin
      pool_vld_d = 1'b0;
    end

    if (xfer) begin
      for (int c = 0; c < C; c++) begin
        work_d[pool_idx(c, int'(row_q >> 1), int'(col_q >> 1))*DW +: DW] = max_lanes[c*DW +: DW];
      end

      if (col_q == LAST) begin
        col_d = '0;
        row_d = (row_q == LAST) ? '0 : row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end

      // Completion wins over a coincident ack so valid never dips between frames.
      if (at_last) begin
        pool_lin_d = work_d;
        pool_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q      <= '0;
      row_q      <= '0;
      work_q     <= '0;
      pool_lin_q <= '0;
      pool_vld_q <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      work_q     <= work_d;
      pool_lin_q <= pool_lin_d;
      pool_vld_q <= pool_vld_d;
    end
  end

  assign pool_lin = pool_lin_q;
  assign pool_vld = pool_vld_q;

endmodule
